rr_decode_arbiter: RTL

//  Round-robin arbiter sharing one resource among 8 requesters. It produces a

---
 rtl/rr_decode_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 8 requesters with registered owner index and one-hot grant.
// Latency: req sampled at one edge, grant outputs updated at that same edge (valid 1 cycle later).
// No backpressure: requesters hold req; MAX_HOLD bounds tenure while others wait.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       gnt_vld,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       preempt
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n;
    logic [CW-1:0] hold_cnt, hold_cnt_n;
    logic          vld_n, pre_n;
    logic [2:0]    idx_n;
    logic [7:0]    onehot_n;

    logic [2:0]    owner, nxt;
    logic [7:0]    others;
    logic [3:0]    pick_idle, pick_other;

    // Returns {found, index} of the first set bit of r searching start, start+1, ... mod 8.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = start + 3'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign owner      = gnt_idx;
    assign nxt        = owner + 3'd1;
    assign others     = req & ~(8'b1 << owner);
    assign pick_idle  = pick(req, ptr);
    // Owner is masked out so the search from owner+1 naturally lands on the next waiter.
    assign pick_other = pick(others, nxt);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        vld_n      = gnt_vld;
        idx_n      = gnt_idx;
        pre_n      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[3]) begin
                    vld_n      = 1'b1;
                    idx_n      = pick_idle[2:0];
                    hold_cnt_n = CW'(1);
                    state_n    = GRANT;
                end else begin
                    vld_n      = 1'b0;
                    idx_n      = 3'd0;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    ptr_n = nxt;
                    if (pick_other[3]) begin
                        idx_n      = pick_other[2:0];
                        hold_cnt_n = CW'(1);
                    end else begin
                        vld_n      = 1'b0;
                        idx_n      = 3'd0;
                        hold_cnt_n = '0;
                        state_n    = IDLE;
                    end
                end else if (hold_cnt == CW'(MAX_HOLD)) begin
                    hold_cnt_n = CW'(1);
                    if (pick_other[3]) begin
                        ptr_n = nxt;
                        idx_n = pick_other[2:0];
                        pre_n = 1'b1;
                    end
                end else begin
                    hold_cnt_n = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_n    = IDLE;
                vld_n      = 1'b0;
                idx_n      = 3'd0;
                hold_cnt_n = '0;
            end
        endcase
        onehot_n = vld_n ? (8'b1 << idx_n) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 3'd0;
            hold_cnt   <= '0;
            gnt_vld    <= 1'b0;
            gnt_idx    <= 3'd0;
            gnt_onehot <= 8'h00;
            preempt    <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            hold_cnt   <= hold_cnt_n;
            gnt_vld    <= vld_n;
            gnt_idx    <= idx_n;
            gnt_onehot <= onehot_n;
            preempt    <= pre_n;
        end
    end

endmodule
